// File: rtl/cenc_conv_encoder.sv
// 802.11a K=7 convolutional encoder (g0=133o, g1=171o): a SIGNAL path re-timed onto the 3x sce_clk_o,
// and a FIFO-buffered payload path tagged with the OFDM symbol index. Rate-3/4 payload puncturing: CENC_PUNCT34_EN.
module cenc_conv_encoder #(
    parameter int N_CBPS      = 288,
    parameter int PLD_FIFO_AW = 13,
    parameter int SCE_FIFO_AW = 4
) (
    input  logic       sce_clk_i,
    input  logic       sce_rst,
    input  logic       sce_clk_o,
    input  logic       sce_di,
    input  logic [5:0] sce_di_init,
    input  logic       sce_di_vld,
    output logic       sce_do,
    output logic       sce_do_vld,
    input  logic       pld_clk,
    input  logic       pld_rst,
    input  logic       pld_di,
    input  logic       pld_di_vld,
    output logic       pld_do,
    output logic       pld_do_vld,
    output logic [3:0] pld_do_sym_num
);

    localparam int SCE_DEPTH = 2 ** SCE_FIFO_AW;
    localparam int PLD_DEPTH = 2 ** PLD_FIFO_AW;
    localparam int PTR_W     = PLD_FIFO_AW + 1;
    localparam int BANK_AW   = PLD_FIFO_AW - 1;
    localparam int BIT_CNT_W = $clog2(N_CBPS);

    function automatic logic [1:0] enc_ab(input logic [5:0] s, input logic x);
        enc_ab[1] = x ^ s[1] ^ s[2] ^ s[4] ^ s[5];
        enc_ab[0] = x ^ s[0] ^ s[1] ^ s[2] ^ s[5];
    endfunction

    // ---------------- SIGNAL path, sce_clk_i side ----------------
    logic [5:0]             sce_state_q, sce_state_d;
    logic                   sce_vld_prev_q;
    logic [SCE_FIFO_AW-1:0] sce_wr_ptr_q, sce_wr_ptr_d;
    logic [SCE_DEPTH-1:0]   sce_mem_q;
    logic [5:0]             sce_enc_state;
    logic [1:0]             sce_ab;

    always_comb begin
        sce_enc_state = sce_state_q;
        if (sce_di_vld && !sce_vld_prev_q) begin
            sce_enc_state = sce_di_init;
        end
        sce_ab       = enc_ab(sce_enc_state, sce_di);
        sce_state_d  = sce_state_q;
        sce_wr_ptr_d = sce_wr_ptr_q;
        if (sce_di_vld) begin
            sce_state_d  = {sce_enc_state[4:0], sce_di};
            sce_wr_ptr_d = sce_wr_ptr_q + SCE_FIFO_AW'(2);
        end
    end

    always_ff @(posedge sce_clk_i or posedge sce_rst) begin
        if (sce_rst) begin
            sce_state_q    <= '0;
            sce_vld_prev_q <= 1'b0;
            sce_wr_ptr_q   <= '0;
        end else begin
            sce_state_q    <= sce_state_d;
            sce_vld_prev_q <= sce_di_vld;
            sce_wr_ptr_q   <= sce_wr_ptr_d;
        end
    end

    always_ff @(posedge sce_clk_i) begin
        if (sce_di_vld) begin
            sce_mem_q[sce_wr_ptr_q]                    <= sce_ab[1];
            sce_mem_q[sce_wr_ptr_q + SCE_FIFO_AW'(1)]  <= sce_ab[0];
        end
    end

    // ---------------- SIGNAL path, sce_clk_o side ----------------
    // Edges are aligned, so the write pointer is read directly; it is stable around every sce_clk_o edge.
    logic [SCE_FIFO_AW-1:0] sce_rd_ptr_q, sce_rd_ptr_d;
    logic                   sce_do_q, sce_do_d;
    logic                   sce_do_vld_q, sce_do_vld_d;

    always_comb begin
        sce_rd_ptr_d = sce_rd_ptr_q;
        sce_do_d     = 1'b0;
        sce_do_vld_d = 1'b0;
        if (sce_rd_ptr_q != sce_wr_ptr_q) begin
            sce_do_d     = sce_mem_q[sce_rd_ptr_q];
            sce_do_vld_d = 1'b1;
            sce_rd_ptr_d = sce_rd_ptr_q + SCE_FIFO_AW'(1);
        end
    end

    always_ff @(posedge sce_clk_o or posedge sce_rst) begin
        if (sce_rst) begin
            sce_rd_ptr_q <= '0;
            sce_do_q     <= 1'b0;
            sce_do_vld_q <= 1'b0;
        end else begin
            sce_rd_ptr_q <= sce_rd_ptr_d;
            sce_do_q     <= sce_do_d;
            sce_do_vld_q <= sce_do_vld_d;
        end
    end

    assign sce_do     = sce_do_q;
    assign sce_do_vld = sce_do_vld_q;

    // ---------------- Payload path ----------------
    logic [5:0]           pld_state_q, pld_state_d;
    logic [PTR_W-1:0]     pld_wr_ptr_q, pld_wr_ptr_d;
    logic [PTR_W-1:0]     pld_rd_ptr_q, pld_rd_ptr_d;
    logic [PTR_W-1:0]     pld_count;
    logic [1:0]           pld_ab;
    logic [1:0]           pld_push_n;
    logic                 pld_bit0, pld_bit1;
    logic                 pld_wr_en0, pld_wr_en1;
    logic                 pld_pop;
    logic                 pld_do_vld_q, pld_do_vld_d;
    logic                 pld_sel_q, pld_sel_d;
    logic [BIT_CNT_W-1:0] pld_bit_cnt_q, pld_bit_cnt_d;
    logic [3:0]           pld_sym_cnt_q, pld_sym_cnt_d;
    logic [3:0]           pld_sym_out_q, pld_sym_out_d;
    logic [1:0]           bank_rd;
`ifdef CENC_PUNCT34_EN
    logic [1:0]           pld_phase_q, pld_phase_d;
`endif

    always_comb begin
        pld_ab      = enc_ab(pld_state_q, pld_di);
        pld_state_d = pld_state_q;
        pld_push_n  = 2'd0;
        pld_bit0    = pld_ab[1];
        pld_bit1    = pld_ab[0];
`ifdef CENC_PUNCT34_EN
        pld_phase_d = pld_phase_q;
`endif
        if (pld_di_vld) begin
            pld_state_d = {pld_state_q[4:0], pld_di};
`ifdef CENC_PUNCT34_EN
            // Triple pattern: A0 B0 | A1 | B2
            case (pld_phase_q)
                2'd0:    pld_push_n = 2'd2;
                2'd1:    pld_push_n = 2'd1;
                default: begin
                    pld_push_n = 2'd1;
                    pld_bit0   = pld_ab[0];
                end
            endcase
            pld_phase_d = (pld_phase_q == 2'd2) ? 2'd0 : pld_phase_q + 2'd1;
`else
            pld_push_n = 2'd2;
`endif
        end

        pld_count    = pld_wr_ptr_q - pld_rd_ptr_q;
        pld_wr_en0   = (pld_push_n != 2'd0) && (pld_count < PTR_W'(PLD_DEPTH));
        pld_wr_en1   = (pld_push_n == 2'd2) && (pld_count < PTR_W'(PLD_DEPTH - 1));
        pld_wr_ptr_d = pld_wr_ptr_q + PTR_W'(pld_wr_en0) + PTR_W'(pld_wr_en1);

        pld_pop       = (pld_count != '0);
        pld_rd_ptr_d  = pld_rd_ptr_q + PTR_W'(pld_pop);
        pld_do_vld_d  = pld_pop;
        pld_sel_d     = pld_sel_q;
        pld_sym_out_d = pld_sym_out_q;
        pld_bit_cnt_d = pld_bit_cnt_q;
        pld_sym_cnt_d = pld_sym_cnt_q;
        if (pld_pop) begin
            pld_sel_d     = pld_rd_ptr_q[0];
            pld_sym_out_d = pld_sym_cnt_q;
            if (pld_bit_cnt_q == BIT_CNT_W'(N_CBPS - 1)) begin
                pld_bit_cnt_d = '0;
                pld_sym_cnt_d = pld_sym_cnt_q + 4'd1;
            end else begin
                pld_bit_cnt_d = pld_bit_cnt_q + BIT_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge pld_clk or posedge pld_rst) begin
        if (pld_rst) begin
            pld_state_q   <= '0;
            pld_wr_ptr_q  <= '0;
            pld_rd_ptr_q  <= '0;
            pld_do_vld_q  <= 1'b0;
            pld_sel_q     <= 1'b0;
            pld_bit_cnt_q <= '0;
            pld_sym_cnt_q <= '0;
            pld_sym_out_q <= '0;
`ifdef CENC_PUNCT34_EN
            pld_phase_q   <= '0;
`endif
        end else begin
            pld_state_q   <= pld_state_d;
            pld_wr_ptr_q  <= pld_wr_ptr_d;
            pld_rd_ptr_q  <= pld_rd_ptr_d;
            pld_do_vld_q  <= pld_do_vld_d;
            pld_sel_q     <= pld_sel_d;
            pld_bit_cnt_q <= pld_bit_cnt_d;
            pld_sym_cnt_q <= pld_sym_cnt_d;
            pld_sym_out_q <= pld_sym_out_d;
`ifdef CENC_PUNCT34_EN
            pld_phase_q   <= pld_phase_d;
`endif
        end
    end

    // Even/odd bit banks: two consecutive pushes always land in different banks,
    // so each bank stays a simple one-write/one-read RAM.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic               bank_mem [2 ** BANK_AW];
        logic               bank_rd_q;
        logic               first_here;
        logic               bank_we;
        logic               bank_wdata;
        logic [BANK_AW-1:0] bank_waddr;

        assign first_here = (pld_wr_ptr_q[0] == 1'(gi));
        assign bank_we    = first_here ? pld_wr_en0 : pld_wr_en1;
        assign bank_wdata = first_here ? pld_bit0 : pld_bit1;
        // A push starting in bank 1 spills its second bit into the next row of bank 0.
        assign bank_waddr = pld_wr_ptr_q[PLD_FIFO_AW-1:1] + BANK_AW'((gi == 0) && pld_wr_ptr_q[0]);

        always_ff @(posedge pld_clk) begin
            if (bank_we) begin
                bank_mem[bank_waddr] <= bank_wdata;
            end
            if (pld_pop && (pld_rd_ptr_q[0] == 1'(gi))) begin
                bank_rd_q <= bank_mem[pld_rd_ptr_q[PLD_FIFO_AW-1:1]];
            end
        end

        assign bank_rd[gi] = bank_rd_q;
    end

    assign pld_do         = pld_do_vld_q & bank_rd[pld_sel_q];
    assign pld_do_vld     = pld_do_vld_q;
    assign pld_do_sym_num = pld_sym_out_q;

endmodule

// File: tb/tb_cenc_conv_encoder.sv
// Self-checking bench for cenc_conv_encoder: SIGNAL first-pair vector table plus scoreboarded
// frames/streams on both paths; follows CENC_PUNCT34_EN when it is defined.
module tb_cenc_conv_encoder;

    localparam int N_CBPS = 288;

    logic       sce_clk_i = 1'b0;
    logic       sce_clk_o = 1'b0;
    logic       pld_clk   = 1'b0;
    logic       sce_rst, sce_di, sce_di_vld;
    logic [5:0] sce_di_init;
    logic       sce_do, sce_do_vld;
    logic       pld_rst, pld_di, pld_di_vld;
    logic       pld_do, pld_do_vld;
    logic [3:0] pld_do_sym_num;

    int checks   = 0;
    int failures = 0;

    logic sce_exp_q[$];
    logic pld_exp_q[$];
    int   sce_vld_cnt  = 0;
    int   pld_pop_idx  = 0;
    int   pld_push_cnt = 0;
    logic [5:0] pld_m_state = '0;
    int   pld_m_phase  = 0;
    logic sce_mon_exp, pld_mon_exp;

    typedef struct {
        logic [5:0] init;
        logic       x;
        logic [1:0] ab;
    } sce_vec_t;
    sce_vec_t sce_tab [9];

    cenc_conv_encoder dut (
        .sce_clk_i      (sce_clk_i),
        .sce_rst        (sce_rst),
        .sce_clk_o      (sce_clk_o),
        .sce_di         (sce_di),
        .sce_di_init    (sce_di_init),
        .sce_di_vld     (sce_di_vld),
        .sce_do         (sce_do),
        .sce_do_vld     (sce_do_vld),
        .pld_clk        (pld_clk),
        .pld_rst        (pld_rst),
        .pld_di         (pld_di),
        .pld_di_vld     (pld_di_vld),
        .pld_do         (pld_do),
        .pld_do_vld     (pld_do_vld),
        .pld_do_sym_num (pld_do_sym_num)
    );

    // sce_clk_i rises at 15, 45, ... together with every third sce_clk_o rise
    initial forever #5 sce_clk_o = ~sce_clk_o;
    initial forever #15 sce_clk_i = ~sce_clk_i;
    initial forever #4 pld_clk = ~pld_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Reference encoder from the generator polynomials; window bit 6 is the newest bit.
    function automatic logic [1:0] ref_enc(input logic [5:0] s, input logic x);
        logic [6:0] w;
        w = {x, s[0], s[1], s[2], s[3], s[4], s[5]};
        return {^(w & 7'o133), ^(w & 7'o171)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge sce_clk_o) begin
        if (sce_do_vld === 1'b1) begin
            sce_vld_cnt++;
            check("sce_pending", 32'(sce_exp_q.size() != 0), 32'd1);
            if (sce_exp_q.size() != 0) begin
                sce_mon_exp = sce_exp_q.pop_front();
                check("sce_do", 32'(sce_do), 32'(sce_mon_exp));
            end
        end
    end

    always @(negedge pld_clk) begin
        if (pld_do_vld === 1'b1) begin
            check("pld_pending", 32'(pld_exp_q.size() != 0), 32'd1);
            if (pld_exp_q.size() != 0) begin
                pld_mon_exp = pld_exp_q.pop_front();
                check("pld_do", 32'(pld_do), 32'(pld_mon_exp));
                check("pld_sym_num", 32'(pld_do_sym_num), 32'((pld_pop_idx / N_CBPS) % 16));
            end
            pld_pop_idx++;
        end
    end

    task automatic pld_drive(input logic x);
        pld_di     = x;
        pld_di_vld = 1'b1;
        @(posedge pld_clk);
        #1;
    endtask

    task automatic pld_send(input logic x);
        logic [1:0] ab;
        ab          = ref_enc(pld_m_state, x);
        pld_m_state = {pld_m_state[4:0], x};
`ifdef CENC_PUNCT34_EN
        case (pld_m_phase)
            0: begin pld_exp_q.push_back(ab[1]); pld_exp_q.push_back(ab[0]); pld_push_cnt += 2; end
            1: begin pld_exp_q.push_back(ab[1]); pld_push_cnt += 1; end
            default: begin pld_exp_q.push_back(ab[0]); pld_push_cnt += 1; end
        endcase
        pld_m_phase = (pld_m_phase + 1) % 3;
`else
        pld_exp_q.push_back(ab[1]);
        pld_exp_q.push_back(ab[0]);
        pld_push_cnt += 2;
`endif
        pld_drive(x);
    endtask

    task automatic pld_model_reset();
        pld_exp_q.delete();
        pld_m_state = '0;
        pld_m_phase = 0;
        pld_pop_idx = 0;
    endtask

    task automatic wait_pld_drain(input string name);
        int n;
        n = 0;
        pld_di_vld = 1'b0;
        while (pld_exp_q.size() != 0 && n < 20000) begin
            @(posedge pld_clk);
            n++;
        end
        repeat (3) @(posedge pld_clk);
        #1;
        check(name, 32'(pld_exp_q.size()), 32'd0);
    endtask

    task automatic wait_sce_drain(input string name);
        int n;
        n = 0;
        while (sce_exp_q.size() != 0 && n < 300) begin
            @(posedge sce_clk_o);
            n++;
        end
        @(posedge sce_clk_i);
        #1;
        check(name, 32'(sce_exp_q.size()), 32'd0);
    endtask

    task automatic sce_frame(input logic [5:0] init, input logic [31:0] data, input int n);
        logic [5:0] s;
        logic [1:0] ab;
        s           = init;
        sce_di_init = init;
        for (int i = 0; i < n; i++) begin
            ab = ref_enc(s, data[i]);
            sce_exp_q.push_back(ab[1]);
            sce_exp_q.push_back(ab[0]);
            s          = {s[4:0], data[i]};
            sce_di     = data[i];
            sce_di_vld = 1'b1;
            @(posedge sce_clk_i);
            #1;
        end
        sce_di_vld = 1'b0;
    endtask

    initial begin
        logic [13:0] imp;
        logic [31:0] data;
        logic [5:0]  init;
        logic [5:0]  s;
        logic [1:0]  ab;
        int          cnt0, push0;

        sce_rst = 1'b1; pld_rst = 1'b1;
        sce_di = 1'b0; sce_di_vld = 1'b0; sce_di_init = '0;
        pld_di = 1'b0; pld_di_vld = 1'b0;
        sce_tab[0] = '{6'b000000, 1'b0, 2'b00};
        sce_tab[1] = '{6'b000000, 1'b1, 2'b11};
        sce_tab[2] = '{6'b111101, 1'b0, 2'b11};
        sce_tab[3] = '{6'b111111, 1'b0, 2'b00};
        sce_tab[4] = '{6'b000001, 1'b0, 2'b01};
        sce_tab[5] = '{6'b010000, 1'b0, 2'b10};
        sce_tab[6] = '{6'b100000, 1'b0, 2'b11};
        sce_tab[7] = '{6'b100000, 1'b1, 2'b00};
        sce_tab[8] = '{6'b001000, 1'b1, 2'b11};

        #47;
        check("rst_sce_do", 32'(sce_do), 32'd0);
        check("rst_sce_do_vld", 32'(sce_do_vld), 32'd0);
        check("rst_pld_do", 32'(pld_do), 32'd0);
        check("rst_pld_do_vld", 32'(pld_do_vld), 32'd0);
        check("rst_pld_sym_num", 32'(pld_do_sym_num), 32'd0);
        $display("reset state checked");
        @(posedge sce_clk_i); #1; sce_rst = 1'b0;
        @(posedge pld_clk); #1; pld_rst = 1'b0;

        // Payload impulse response
`ifndef CENC_PUNCT34_EN
        imp = 14'b11_01_11_11_00_10_11;
        for (int i = 13; i >= 0; i--) pld_exp_q.push_back(imp[i]);
        repeat (6) pld_exp_q.push_back(1'b0);
        pld_drive(1'b1);
        repeat (9) pld_drive(1'b0);
        pld_pop_idx = pld_pop_idx;
`else
        pld_send(1'b1);
        repeat (9) pld_send(1'b0);
`endif
        wait_pld_drain("pld_impulse_drain");
        $display("payload impulse: 10 inputs, observed bits=%0d", pld_pop_idx);

        // All-zero payload
        cnt0 = pld_pop_idx; push0 = pld_push_cnt;
        repeat (100) pld_send(1'b0);
        wait_pld_drain("pld_zero_drain");
        check("pld_zero_count", 32'(pld_pop_idx - cnt0), 32'(pld_push_cnt - push0));
        $display("payload zeros: 100 inputs, %0d coded bits", pld_pop_idx - cnt0);

        // Random payload with idle gaps
        for (int i = 0; i < 200; i++) begin
            pld_send(1'($urandom_range(0, 1)));
            if ((i % 17) == 16) begin
                pld_di_vld = 1'b0;
                @(posedge pld_clk); #1;
            end
        end
        wait_pld_drain("pld_rand_drain");
        $display("payload random: 200 inputs, total observed bits=%0d", pld_pop_idx);

        // Payload reset mid-stream
        repeat (60) pld_send(1'($urandom_range(0, 1)));
        #1; pld_rst = 1'b1; pld_di_vld = 1'b0;
        #1;
        check("pld_midrst_vld", 32'(pld_do_vld), 32'd0);
        check("pld_midrst_do", 32'(pld_do), 32'd0);
        check("pld_midrst_sym", 32'(pld_do_sym_num), 32'd0);
        pld_model_reset();
        repeat (2) @(posedge pld_clk);
        #1; pld_rst = 1'b0;
        repeat (40) pld_send(1'($urandom_range(0, 1)));
        wait_pld_drain("pld_after_rst_drain");
        $display("payload mid-stream reset: 40 inputs after reset, bits=%0d", pld_pop_idx);

        // Long continuous payload: symbol index wrap
        #1; pld_rst = 1'b1;
        pld_model_reset();
        @(posedge pld_clk); #1; pld_rst = 1'b0;
        repeat (4320) pld_send(1'($urandom_range(0, 1)));
        wait_pld_drain("pld_long_drain");
`ifdef CENC_PUNCT34_EN
        check("pld_long_count", 32'(pld_pop_idx), 32'd5760);
`else
        check("pld_long_count", 32'(pld_pop_idx), 32'd8640);
`endif
        $display("payload long: 4320 inputs, %0d coded bits", pld_pop_idx);

        // SIGNAL first-pair table, one single-bit frame per entry
        @(posedge sce_clk_i); #1;
        for (int i = 0; i < 9; i++) begin
            sce_di_init = sce_tab[i].init;
            sce_di      = sce_tab[i].x;
            sce_di_vld  = 1'b1;
            sce_exp_q.push_back(sce_tab[i].ab[1]);
            sce_exp_q.push_back(sce_tab[i].ab[0]);
            @(posedge sce_clk_i); #1;
            sce_di_vld = 1'b0;
            wait_sce_drain("sce_tab_drain");
            $display("sce vector %0d: init=%b x=%b expect AB=%b", i, sce_tab[i].init, sce_tab[i].x, sce_tab[i].ab);
        end

        // 32-bit SIGNAL frames
        for (int f = 0; f < 3; f++) begin
            cnt0 = sce_vld_cnt;
            init = 6'($urandom);
            data = $urandom;
            sce_frame(init, data, 32);
            wait_sce_drain("sce_frame_drain");
            check("sce_frame_vld_count", 32'(sce_vld_cnt - cnt0), 32'd64);
            $display("sce frame %0d: init=%b data=%h pulses=%0d", f, init, data, sce_vld_cnt - cnt0);
        end

        // SIGNAL reset mid-frame, then a fresh frame
        init = 6'b101011;
        s    = init;
        sce_di_init = init;
        for (int i = 0; i < 10; i++) begin
            ab = ref_enc(s, 1'b1);
            sce_exp_q.push_back(ab[1]);
            sce_exp_q.push_back(ab[0]);
            s = {s[4:0], 1'b1};
            sce_di = 1'b1; sce_di_vld = 1'b1;
            @(posedge sce_clk_i); #1;
        end
        #1; sce_rst = 1'b1; sce_di_vld = 1'b0;
        #1;
        check("sce_midrst_vld", 32'(sce_do_vld), 32'd0);
        check("sce_midrst_do", 32'(sce_do), 32'd0);
        sce_exp_q.delete();
        repeat (2) @(posedge sce_clk_i);
        #1; sce_rst = 1'b0;
        cnt0 = sce_vld_cnt;
        sce_frame(6'b111101, 32'h0000_A5C3, 16);
        wait_sce_drain("sce_after_rst_drain");
        check("sce_after_rst_count", 32'(sce_vld_cnt - cnt0), 32'd32);
        $display("sce mid-frame reset: new frame pulses=%0d", sce_vld_cnt - cnt0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
